// File: rtl/jtag_vdr_multi.sv
// Multi-channel JTAG virtual data register: one shared DR feeding NUM_CHAN RAM ports.
// Optional VDR_ADDR_WRAP_EN: address increments wrap inside ADDR_MASK (ring buffer).

module jtag_vdr_chan #(
  parameter int                   DR_LENGTH = 32,
  parameter logic [DR_LENGTH-1:0] WRAP_MASK = '1
) (
  input  logic                 tck,
  input  logic                 reset,
  input  logic [DR_LENGTH-1:0] vdr,
  input  logic                 ld_waddr,
  input  logic                 ld_raddr,
  input  logic                 ld_stride,
  input  logic                 ld_wdata,
  input  logic                 arm_rd,
  input  logic                 inc_w,
  input  logic                 inc_r,
  input  logic                 stb_w,
  output logic [DR_LENGTH-1:0] waddr,
  output logic [DR_LENGTH-1:0] raddr,
  output logic [DR_LENGTH-1:0] wdata,
  output logic                 wram_enable
);
  logic [DR_LENGTH-1:0] stride, waddr_inc, raddr_inc;
  logic                 warm, rarm;

  // With an all-ones mask this reduces to a plain modulo add.
  assign waddr_inc = (waddr & ~WRAP_MASK) | ((waddr + stride) & WRAP_MASK);
  assign raddr_inc = (raddr & ~WRAP_MASK) | ((raddr + stride) & WRAP_MASK);

  always_ff @(posedge tck) begin
    if (reset) begin
      waddr       <= '0;
      raddr       <= '0;
      wdata       <= '0;
      stride      <= DR_LENGTH'(1);
      warm        <= 1'b0;
      rarm        <= 1'b0;
      wram_enable <= 1'b0;
    end else begin
      wram_enable <= stb_w;
      if (ld_stride) stride <= vdr;
      if (ld_wdata) begin
        wdata <= vdr;
        warm  <= 1'b1;
      end
      // An address load beats a same-cycle increment and disarms any pending one.
      if (ld_waddr) begin
        waddr <= vdr;
        warm  <= 1'b0;
      end else if (inc_w && warm) begin
        waddr <= waddr_inc;
      end
      if (arm_rd) rarm <= 1'b1;
      if (ld_raddr) begin
        raddr <= vdr;
        rarm  <= 1'b0;
      end else if (inc_r && rarm) begin
        raddr <= raddr_inc;
      end
    end
  end
endmodule

module jtag_vdr_multi #(
  parameter int                   DR_LENGTH     = 32,
  parameter int                   NUM_CHAN      = 2,
  parameter int                   CHAN_W        = 4,
  parameter logic [DR_LENGTH-1:0] IDENT         = DR_LENGTH'(32'h97d2f9ce),
  parameter logic [DR_LENGTH-1:0] FLAGS_INIT    = DR_LENGTH'('h99),
  parameter int                   WR_STROBE_DLY = 5,
  parameter int                   INC_DLY       = 7,
  parameter logic [DR_LENGTH-1:0] ADDR_MASK     = DR_LENGTH'('hFF)
) (
  input  logic                          tck,
  input  logic                          reset,
  input  logic                          tdi,
  output logic                          vdr_tdo,
  input  logic                          capture_dr,
  input  logic                          shift_dr,
  input  logic                          update_dr,
  input  logic [CHAN_W-1:0]             chan_sel,
  input  logic                          ident_enable,
  input  logic                          flags_enable,
  input  logic                          stride_enable,
  input  logic                          raddr_enable,
  input  logic                          waddr_enable,
  input  logic                          rdata_enable,
  input  logic                          wdata_enable,
  input  logic [NUM_CHAN*DR_LENGTH-1:0] rdata_in,
  output logic [NUM_CHAN*DR_LENGTH-1:0] wdata_out,
  output logic [NUM_CHAN*DR_LENGTH-1:0] waddr_out,
  output logic [NUM_CHAN*DR_LENGTH-1:0] raddr_out,
  output logic [NUM_CHAN-1:0]           wram_enable,
  output logic [DR_LENGTH-1:0]          flags_out
);
  localparam int STAGES = INC_DLY - 1;
  localparam int CNT_W  = $clog2(DR_LENGTH);
`ifdef VDR_ADDR_WRAP_EN
  localparam logic [DR_LENGTH-1:0] WRAP_MASK = ADDR_MASK;
`else
  localparam logic [DR_LENGTH-1:0] WRAP_MASK = ADDR_MASK | {DR_LENGTH{1'b1}};
`endif

  logic [DR_LENGTH-1:0]          vdr, flags, rd_sel;
  logic [CNT_W-1:0]              wr_count;
  logic                          latch_pend, cap_rd;
  logic [CHAN_W-1:0]             latch_ch;
  logic [STAGES:0]               wvld_pipe, rvld_pipe;
  logic [STAGES:0][CHAN_W-1:0]   wch_pipe, rch_pipe;

  assign vdr_tdo   = vdr[0];
  assign flags_out = flags;
  assign cap_rd    = capture_dr & rdata_enable;

  always_comb begin
    rd_sel = '0;
    for (int n = 0; n < NUM_CHAN; n++)
      if (chan_sel == CHAN_W'(n)) rd_sel = rdata_in[n*DR_LENGTH +: DR_LENGTH];
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      vdr   <= '0;
      flags <= FLAGS_INIT;
    end else begin
      if (capture_dr && ident_enable)      vdr <= IDENT;
      else if (cap_rd)                     vdr <= rd_sel;
      else if (shift_dr)                   vdr <= {tdi, vdr[DR_LENGTH-1:1]};
      if (update_dr && flags_enable)       flags <= vdr;
    end
  end

  // Word counter runs only inside a wdata scan; a full word latches on the following cycle.
  always_ff @(posedge tck) begin
    if (reset) begin
      wr_count   <= '0;
      latch_pend <= 1'b0;
      latch_ch   <= '0;
    end else begin
      latch_pend <= 1'b0;
      if (!wdata_enable) begin
        wr_count <= '0;
      end else if (shift_dr) begin
        if (wr_count == CNT_W'(DR_LENGTH-1)) begin
          wr_count   <= '0;
          latch_pend <= 1'b1;
          latch_ch   <= chan_sel;
        end else begin
          wr_count <= wr_count + 1'b1;
        end
      end
    end
  end

  // Delay pipes carry the channel index so later chan_sel changes cannot redirect them.
  always_ff @(posedge tck) begin
    if (reset) begin
      wvld_pipe <= '0;
      rvld_pipe <= '0;
      wch_pipe  <= '0;
      rch_pipe  <= '0;
    end else begin
      wvld_pipe <= {wvld_pipe[STAGES-1:0], latch_pend};
      wch_pipe  <= {wch_pipe[STAGES-1:0], latch_ch};
      rvld_pipe <= {rvld_pipe[STAGES-1:0], cap_rd};
      rch_pipe  <= {rch_pipe[STAGES-1:0], chan_sel};
    end
  end

  for (genvar n = 0; n < NUM_CHAN; n++) begin : g_chan
    localparam logic [CHAN_W-1:0] ID = CHAN_W'(n);
    logic sel;
    assign sel = (chan_sel == ID);

    jtag_vdr_chan #(
      .DR_LENGTH (DR_LENGTH),
      .WRAP_MASK (WRAP_MASK)
    ) u_chan (
      .tck         (tck),
      .reset       (reset),
      .vdr         (vdr),
      .ld_waddr    (update_dr & waddr_enable & sel),
      .ld_raddr    (update_dr & raddr_enable & sel),
      .ld_stride   (update_dr & stride_enable & sel),
      .ld_wdata    (latch_pend && latch_ch == ID),
      .arm_rd      (cap_rd & sel),
      .inc_w       (wvld_pipe[STAGES] && wch_pipe[STAGES] == ID),
      .inc_r       (rvld_pipe[STAGES] && rch_pipe[STAGES] == ID),
      .stb_w       (wvld_pipe[WR_STROBE_DLY-1] && wch_pipe[WR_STROBE_DLY-1] == ID),
      .waddr       (waddr_out[n*DR_LENGTH +: DR_LENGTH]),
      .raddr       (raddr_out[n*DR_LENGTH +: DR_LENGTH]),
      .wdata       (wdata_out[n*DR_LENGTH +: DR_LENGTH]),
      .wram_enable (wram_enable[n])
    );
  end
endmodule

// File: tb/tb_jtag_vdr_multi.sv
// Directed bench for jtag_vdr_multi: scoreboarded strobes and read words, 2 channels.
module tb_jtag_vdr_multi;
  localparam int DL = 32, NC = 2, CW = 4;

  logic            tck = 1'b0, reset = 1'b1, tdi = 1'b0, vdr_tdo;
  logic            capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
  logic [CW-1:0]   chan_sel = '0;
  logic            ident_enable = 1'b0, flags_enable = 1'b0, stride_enable = 1'b0;
  logic            raddr_enable = 1'b0, waddr_enable = 1'b0, rdata_enable = 1'b0, wdata_enable = 1'b0;
  logic [NC*DL-1:0] rdata_in, wdata_out, waddr_out, raddr_out;
  logic [NC-1:0]   wram_enable;
  logic [DL-1:0]   flags_out;

  int checks = 0, failures = 0, n_stb1 = 0;
  logic [63:0] wq[$];
  logic [31:0] rq[$];

  always #5 tck = ~tck;

  // RAM stand-in: channel 0 returns raddr + 0x1000.
  assign rdata_in = {raddr_out[63:32] ^ 32'h5A5A0000, raddr_out[31:0] + 32'h1000};

  jtag_vdr_multi dut (
    .tck(tck), .reset(reset), .tdi(tdi), .vdr_tdo(vdr_tdo),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .chan_sel(chan_sel),
    .ident_enable(ident_enable), .flags_enable(flags_enable), .stride_enable(stride_enable),
    .raddr_enable(raddr_enable), .waddr_enable(waddr_enable), .rdata_enable(rdata_enable),
    .wdata_enable(wdata_enable),
    .rdata_in(rdata_in), .wdata_out(wdata_out), .waddr_out(waddr_out), .raddr_out(raddr_out),
    .wram_enable(wram_enable), .flags_out(flags_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tck);
    @(negedge tck);
  endtask

  task automatic set_ir(input int c);
    ident_enable  = (c == 1);
    flags_enable  = (c == 2);
    stride_enable = (c == 3);
    raddr_enable  = (c == 4);
    waddr_enable  = (c == 5);
    rdata_enable  = (c == 6);
    wdata_enable  = (c == 7);
  endtask

  task automatic shift_word(input logic [31:0] din, output logic [31:0] dout);
    for (int i = 0; i < 32; i++) begin
      dout[i]  = vdr_tdo;
      tdi      = din[i];
      shift_dr = 1'b1;
      step();
    end
  endtask

  task automatic load_reg(input int c, input logic [31:0] v);
    logic [31:0] junk;
    set_ir(c);
    shift_word(v, junk);
    shift_dr  = 1'b0;
    update_dr = 1'b1;
    step();
    update_dr = 1'b0;
    set_ir(0);
  endtask

  task automatic read_scan(output logic [31:0] w);
    set_ir(6);
    capture_dr = 1'b1;
    step();
    capture_dr = 1'b0;
    shift_word(32'h0, w);
    shift_dr = 1'b0;
    set_ir(0);
    step();
  endtask

  // Strobe monitor: every channel-1 pulse consumes one expected (waddr, wdata) pair.
  always @(negedge tck) begin
    if (!reset && wram_enable[0]) chk("ch0_strobe", 128'(wram_enable[0]), 128'd0);
    if (!reset && wram_enable[1]) begin
      n_stb1++;
      if (wq.size() == 0) chk("ch1_unexpected_strobe", 128'(wq.size()), 128'd1);
      else chk("ch1_strobe", {waddr_out[63:32], wdata_out[63:32]}, 128'(wq.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] exp_r;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_flags", flags_out, 32'h99);
    chk("rst_tdo", vdr_tdo, 1'b0);
    chk("rst_wram", wram_enable, 2'b00);
    chk("rst_waddr", waddr_out, 64'h0);
    chk("rst_raddr", raddr_out, 64'h0);
    chk("rst_wdata", wdata_out, 64'h0);

    // Ident capture streams out LSB first
    set_ir(1); capture_dr = 1'b1; step(); capture_dr = 1'b0;
    shift_word(32'h0, w); shift_dr = 1'b0; set_ir(0);
    chk("ident", w, 32'h97d2f9ce);
    load_reg(2, 32'h5A);
    chk("flags", flags_out, 32'h5A);

    // Continuous streaming writes on channel 1 with stride 2
    chan_sel = 1;
    load_reg(5, 32'h10);
    load_reg(3, 32'h2);
    wq.push_back({32'h10, 32'hA});
    wq.push_back({32'h12, 32'hB});
    wq.push_back({32'h14, 32'hC});
    set_ir(7);
    shift_word(32'hA, w); shift_word(32'hB, w); shift_word(32'hC, w);
    shift_dr = 1'b0;
    repeat (12) step();
    set_ir(0);
    chk("wr_strobe_count", n_stb1, 3);
    chk("wr_queue_empty", wq.size(), 0);
    chk("waddr_after_writes", waddr_out[63:32], 32'h16);
    chk("wdata_last", wdata_out[63:32], 32'hC);

    // Auto-incrementing reads on channel 0
    chan_sel = 0;
    load_reg(4, 32'h40);
    for (int k = 0; k < 3; k++) rq.push_back(32'h1040 + 32'(k));
    repeat (3) begin
      read_scan(w);
      chk("rdata_word", w, rq.pop_front());
    end
    chk("raddr_after_reads", raddr_out[31:0], 32'h43);

    // raddr update lands on the exact cycle of the pending increment
    set_ir(6); capture_dr = 1'b1; step(); capture_dr = 1'b0;
    set_ir(4); tdi = 1'b1; shift_dr = 1'b1;
    repeat (6) step();
    shift_dr = 1'b0; update_dr = 1'b1; step(); update_dr = 1'b0; set_ir(0);
    exp_r = (32'h1043 >> 6) | 32'hFC000000;
    chk("raddr_update_wins", raddr_out[31:0], exp_r);
    repeat (10) step();
    chk("raddr_no_late_inc", raddr_out[31:0], exp_r);
    chk("raddr_ch1_untouched", raddr_out[63:32], 32'h0);

    // Reset between latch and strobe cancels everything
    chan_sel = 1;
    set_ir(7);
    shift_word(32'h55, w);
    shift_dr = 1'b0; set_ir(0);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    repeat (12) step();
    chk("rst_mid_no_strobe", n_stb1, 3);
    chk("rst_mid_waddr", waddr_out, 64'h0);
    chk("rst_mid_raddr", raddr_out, 64'h0);
    chk("rst_mid_wdata", wdata_out, 64'h0);
    chk("rst_mid_flags", flags_out, 32'h99);

    // Strides back at 1 on both channels
    chan_sel = 0;
    rq.push_back(32'h1000);
    rq.push_back(32'h1001);
    repeat (2) begin
      read_scan(w);
      chk("stride_rst_read", w, rq.pop_front());
    end
    chan_sel = 1;
    wq.push_back({32'h0, 32'h77});
    set_ir(7);
    shift_word(32'h77, w);
    shift_dr = 1'b0;
    repeat (12) step();
    set_ir(0);
    chk("stride_rst_strobes", n_stb1, 4);
    chk("stride_rst_waddr", waddr_out[63:32], 32'h1);

`ifdef VDR_ADDR_WRAP_EN
    load_reg(5, 32'h1FE);
    load_reg(3, 32'h1);
    wq.push_back({32'h1FE, 32'h1});
    wq.push_back({32'h1FF, 32'h2});
    wq.push_back({32'h100, 32'h3});
    set_ir(7);
    shift_word(32'h1, w); shift_word(32'h2, w); shift_word(32'h3, w);
    shift_dr = 1'b0;
    repeat (12) step();
    set_ir(0);
    chk("wrap_strobes", n_stb1, 7);
    chk("wrap_waddr_end", waddr_out[63:32], 32'h101);
`endif

    chk("final_queue_empty", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
